id_ex_stage: RTL

- ID/EX pipeline register for the LEGv8 five-stage core. Sits directly downstream of the decode-stage control unit and register file.
- Latches decoded control signals, operands, immediate, PC and destination register each cycle.
- Detects load-use hazards against the instruction already in EX. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Honours a branch flush and a global hold, and counts inserted bubbles.

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the LEGv8 five-stage core.
// Latches decode outputs, detects load-use hazards against EX, inserts bubbles and counts them.
module id_ex_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_uncondbranch,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_alu_op,
  input  logic [10:0]           id_opcode,
  input  logic [PC_WIDTH-1:0]   id_pc,
  input  logic [DATA_WIDTH-1:0] id_read_data1,
  input  logic [DATA_WIDTH-1:0] id_read_data2,
  input  logic [DATA_WIDTH-1:0] id_sign_ext,
  input  logic [4:0]            id_read_reg1,
  input  logic [4:0]            id_read_reg2,
  input  logic [4:0]            id_write_reg,
  output logic                  ex_uncondbranch,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic [1:0]            ex_alu_op,
  output logic [10:0]           ex_opcode,
  output logic [PC_WIDTH-1:0]   ex_pc,
  output logic [DATA_WIDTH-1:0] ex_read_data1,
  output logic [DATA_WIDTH-1:0] ex_read_data2,
  output logic [DATA_WIDTH-1:0] ex_sign_ext,
  output logic [4:0]            ex_write_reg,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  bubble_count
);

  localparam logic [4:0] XZR = 5'd31;

  // Control bundle: {uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  logic [8:0]            ctrl_q, ctrl_d, id_ctrl;
  logic [10:0]           opcode_q, opcode_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]            wreg_q, wreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hazard;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign id_ctrl = {id_uncondbranch, id_branch, id_mem_read, id_mem_to_reg,
                    id_mem_write, id_alu_src, id_reg_write, id_alu_op};

  // ctrl_q[6] is mem_read of the instruction currently in EX
  assign hazard = ctrl_q[6] && (wreg_q != XZR) &&
                  ((wreg_q == id_read_reg1) || (wreg_q == id_read_reg2));

  assign stall = hazard && !flush && !hold && !reset;

  always_comb begin
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    wreg_d   = wreg_q;
    cnt_d    = cnt_q;
    if (hold) begin
      // freeze everything
    end else if (flush) begin
      ctrl_d   = '0;
      opcode_d = '0;
      pc_d     = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      wreg_d   = '0;
    end else begin
      ctrl_d   = hazard ? 9'd0 : id_ctrl;
      opcode_d = id_opcode;
      pc_d     = id_pc;
      rd1_d    = id_read_data1;
      rd2_d    = id_read_data2;
      imm_d    = id_sign_ext;
      wreg_d   = id_write_reg;
      if (hazard) cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      opcode_q <= '0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      wreg_q   <= '0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      wreg_q   <= wreg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign {ex_uncondbranch, ex_branch, ex_mem_read, ex_mem_to_reg,
          ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op} = ctrl_q;
  assign ex_opcode     = opcode_q;
  assign ex_pc         = pc_q;
  assign ex_read_data1 = rd1_q;
  assign ex_read_data2 = rd2_q;
  assign ex_sign_ext   = imm_q;
  assign ex_write_reg  = wreg_q;
  assign bubble_count  = cnt_q;

endmodule
